// File: rtl/button_conditioner.sv
// Push-button front end: per-lane two-flop synchronizer, counter debouncer and
// a registered single-cycle pulse on every accepted press.
module button_conditioner #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] ButtonRaw,
  output logic [WIDTH-1:0] ButtonLevel,
  output logic [WIDTH-1:0] ButtonVector
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] pressed;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  assign pressed = ACTIVE_LOW ? ~ButtonRaw : ButtonRaw;

  // Any sample agreeing with the accepted level clears the count, so only an
  // unbroken run of DEBOUNCE_CYCLES disagreeing samples changes the level.
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s2_q[i];
        pulse_d[i] = s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= pressed;
      s2_q    <= s1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign ButtonLevel  = level_q;
  assign ButtonVector = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench for button_conditioner: a window-based reference model
// predicts levels and press pulses; a negedge monitor compares every cycle.
module tb_button_conditioner;

  localparam int W   = 3;
  localparam int DCY = 8;
  localparam int LAT = DCY + 2;  // cycles from driving a pin to seeing its pulse

  logic         Clock = 1'b0;
  logic         Reset;
  logic [W-1:0] ButtonRaw;
  logic [W-1:0] ButtonLevel;
  logic [W-1:0] ButtonVector;

  button_conditioner #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DCY), .ACTIVE_LOW(1'b1)
  ) dut (
    .Clock(Clock), .Reset(Reset), .ButtonRaw(ButtonRaw),
    .ButtonLevel(ButtonLevel), .ButtonVector(ButtonVector)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  int unsigned cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each lane: the synchronized view of a pin is its sample from two edges
  // earlier; the level flips once the last DCY synchronized samples all differ.
  logic [34:0] exp_q [$];  // {cycle seen, expected pulse vector}
  bit          m_lvl [W];
  bit          pline [W][$];
  bit          win   [W][$];

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < W; i++) begin
        m_lvl[i] = 1'b0;
        pline[i].delete();
        pline[i].push_back(1'b0);
        pline[i].push_back(1'b0);
        win[i].delete();
      end
    end else begin
      logic [W-1:0] vec;
      logic [W-1:0] p;
      bool_all_differ: begin end
      vec = '0;
      p   = ~ButtonRaw;
      for (int i = 0; i < W; i++) begin
        bit s;
        bit all_diff;
        pline[i].push_back(p[i]);
        s = pline[i].pop_front();
        win[i].push_back(s);
        if (win[i].size() > DCY) void'(win[i].pop_front());
        all_diff = (win[i].size() == DCY);
        foreach (win[i][k]) if (win[i][k] == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[i] = ~m_lvl[i];
          if (m_lvl[i]) vec[i] = 1'b1;
          win[i].delete();
        end
      end
      if (vec != '0) exp_q.push_back({cyc + 32'd1, vec});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int unsigned pc [W];
  int unsigned last_pulse [W];
  logic [W-1:0] last_vec = '0;

  always @(negedge Clock) begin
    logic [W-1:0] exp_lvl;
    logic [34:0]  e;
    for (int i = 0; i < W; i++) exp_lvl[i] = m_lvl[i];
    check("level", 32'(ButtonLevel), 32'(exp_lvl));
    while (exp_q.size() > 0 && exp_q[0][34:3] < cyc) begin
      e = exp_q.pop_front();
      if (Reset) continue;
      check("missed_pulse", 32'(0), 32'(e[2:0]));
    end
    if (Reset) begin
      while (exp_q.size() > 0 && exp_q[0][34:3] == cyc) void'(exp_q.pop_front());
      check("pulse_in_reset", 32'(ButtonVector), 32'(0));
    end else if (exp_q.size() > 0 && exp_q[0][34:3] == cyc) begin
      e = exp_q.pop_front();
      check("pulse", 32'(ButtonVector), 32'(e[2:0]));
    end else begin
      check("no_pulse", 32'(ButtonVector), 32'(0));
    end
    if (ButtonVector != '0) begin
      last_vec = ButtonVector;
      for (int i = 0; i < W; i++) begin
        if (ButtonVector[i]) begin
          pc[i]++;
          last_pulse[i] = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [W-1:0] press = '0;

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  task automatic set_press(input logic [W-1:0] v);
    press     = v;
    ButtonRaw = ~v;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < W; i++) pc[i] = 0;
    last_vec = '0;
  endtask

  task automatic release_all();
    set_press('0);
    step(3 * DCY);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned d;
    int hold [W];

    // 1: reset held with all pins pressed, then release
    Reset = 1'b1;
    set_press('1);
    clear_counts();
    step(6);
    Reset = 1'b0;
    d = cyc;
    step(3 * DCY);
    check("s1_cnt0", pc[0], 1);
    check("s1_cnt2", pc[2], 1);
    check("s1_vec", 32'(last_vec), 32'h7);
    check("s1_lat", last_pulse[1] - d, LAT);
    release_all();

    // 2: clean press on bit0
    clear_counts();
    set_press(3'b001);
    d = cyc;
    step(40);
    check("s2_cnt", pc[0], 1);
    check("s2_lat", last_pulse[0] - d, LAT);
    release_all();

    // 3: bounce on bit1 then settle pressed
    clear_counts();
    for (int r = 0; r < 6; r++) begin
      set_press(3'b010); step(3);
      set_press(3'b000); step(2);
    end
    check("s3_bounce", pc[1], 0);
    set_press(3'b010);
    d = cyc;
    step(30);
    check("s3_cnt", pc[1], 1);
    check("s3_lat", last_pulse[1] - d, LAT);
    release_all();

    // 4: short release gap is absorbed, long gap gives a second press
    clear_counts();
    set_press(3'b100); step(20);
    set_press(3'b000); step(5);
    set_press(3'b100); step(20);
    check("s4_short_cnt", pc[2], 1);
    check("s4_level", 32'(ButtonLevel[2]), 1);
    set_press(3'b000); step(12);
    set_press(3'b100);
    d = cyc;
    step(20);
    check("s4_long_cnt", pc[2], 2);
    check("s4_lat", last_pulse[2] - d, LAT);
    release_all();

    // 5: simultaneous press, then bit0 two cycles late
    clear_counts();
    set_press(3'b111); step(20);
    check("s5_vec", 32'(last_vec), 32'h7);
    release_all();
    clear_counts();
    set_press(3'b110); step(2);
    set_press(3'b111); step(20);
    check("s5_skew", last_pulse[0] - last_pulse[1], 2);
    release_all();

    // 6: reset mid-count, then reset on the pulse cycle
    clear_counts();
    set_press(3'b001); step(7);
    Reset = 1'b1; step(1); Reset = 1'b0;
    d = cyc;
    step(20);
    check("s6_cnt", pc[0], 1);
    check("s6_lat", last_pulse[0] - d, LAT);
    release_all();
    clear_counts();
    set_press(3'b010); step(LAT);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    check("s6_killed", pc[1], 0);
    step(20);
    check("s6_after_kill", pc[1], 1);
    release_all();

    // random bouncing with occasional resets
    for (int i = 0; i < W; i++) hold[i] = 1;
    for (int t = 0; t < 3000; t++) begin
      logic [W-1:0] v;
      v = press;
      for (int i = 0; i < W; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          v[i] = ~v[i];
          hold[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, DCY - 1))
                                                : int'($urandom_range(DCY, 4 * DCY));
        end
      end
      set_press(v);
      if ($urandom_range(0, 299) == 0) Reset = 1'b1;
      else if (Reset && $urandom_range(0, 1) == 0) Reset = 1'b0;
      step(1);
    end
    Reset = 1'b0;
    release_all();

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end for the player button inputs: synchronizes the raw board push-buttons, debounces each one independently, and emits a single-cycle press pulse per button. Its `ButtonVector` output is the button vector that the button decoder routes to the selected player slot. Each decoder input therefore sees exactly one clean, clock-aligned pulse per physical press.

## Interface

Parameters:
- `WIDTH`, default 3: number of buttons.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a level change. This is 1 ms at 50 MHz. Legal range is ≥ 2.
- `ACTIVE_LOW`, default 1:
  - 1: a raw pin reads 0 when pressed, as on the board keys.
  - 0: a raw pin reads 1 when pressed.

Ports:
- `Clock`, input, 1 bit: single system clock; all state changes on its rising edge.
- `Reset`, input, 1 bit: asynchronous, active-high reset.
- `ButtonRaw`, input, `WIDTH` bits: asynchronous raw button pins.
- `ButtonLevel`, output, `WIDTH` bits: debounced level per button, 1 = pressed.
- `ButtonVector`, output, `WIDTH` bits: one-cycle pulse per bit on each accepted press (0→1 of `ButtonLevel`). Feeds the decoder's `ButtonVector` input.

## Operation

- The design uses one independent lane per bit. No state is shared between lanes.
- **Normalize:** `p = ACTIVE_LOW ? ~ButtonRaw[i] : ButtonRaw[i]`, so 1 means pressed.
- **Synchronize:** `p` passes through a two-flop synchronizer, `s1` then `s2`. Only `s2` is used downstream.
- **Debounce counter:** `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide and unsigned. It never wraps. On each edge:
  - If `s2 == ButtonLevel[i]`, then `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, then `ButtonLevel[i] <= s2` and `cnt <= 0`.
  - Else `cnt <= cnt + 1`.
- **Glitch rejection:** any return of `s2` to the accepted level before the count completes clears `cnt`. The count then restarts from zero on the next disagreement. Bounce shorter than `DEBOUNCE_CYCLES` is fully rejected.
- **Pulse:** `ButtonVector[i]` is a register.
  - It is set to 1 on the same edge that `ButtonLevel[i]` goes 0→1.
  - It is 0 on every other edge.
  - Release (1→0) produces no pulse.
  - A held button produces exactly one pulse, with no auto-repeat.
- **Simultaneous events:** several lanes may pulse in the same cycle. Each lane's pulse is independent; there is no priority or arbitration.
- **Reset values** (asynchronous, while `Reset` = 1):
  - `s1 = s2 = 0`, meaning not pressed.
  - `cnt = 0`.
  - `ButtonLevel = 0`.
  - `ButtonVector = 0`.
- **Release of reset:**
  - A button already held when `Reset` deasserts is treated as a new press: it is accepted after the normal latency and pulses once.
  - Asserting `Reset` mid-count abandons the count.
  - Asserting `Reset` in the same cycle as a pulse kills that pulse immediately.

## Timing

- **Press latency:** `p` first sampled high at edge k gives:
  - `s2` = 1 after edge k+1.
  - `ButtonLevel` = 1 and `ButtonVector` = 1 after edge k+1+`DEBOUNCE_CYCLES`.
  - `ButtonVector` = 0 again after the following edge.
- **Release latency:** the same `DEBOUNCE_CYCLES`+1 edges, with no pulse.
- **Minimum interval:** two accepted presses on one lane are at least 2·`DEBOUNCE_CYCLES` cycles apart. This is one press debounce plus one release debounce.
- **Output timing:** all outputs are registered, with no combinational path from `ButtonRaw` or `Reset` release to the outputs. `Reset` assertion clears the outputs asynchronously.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=8, `WIDTH`=3, `ACTIVE_LOW`=1.

1. **Reset:** `Reset`=1 with `ButtonRaw`=3'b000 (all pressed) → `ButtonLevel`=0 and `ButtonVector`=0 throughout. After release, all three pulse together 9 edges later.
2. **Clean press:** bit0 driven low at edge 0 and held 40 cycles → `ButtonLevel[0]`=1 and `ButtonVector`=3'b001 after edge 9, for exactly one cycle. No further pulses while held.
3. **Bounce rejection:** bit1 toggled with a 3-cycle-low/2-cycle-high pattern for 30 cycles, then held low → zero pulses during bouncing. Exactly one pulse, 3'b010, occurs 9 edges after the final stable low sample.
4. **Release and re-press:**
   - bit2 pressed, then released at cycle 20, then re-pressed at cycle 25 → no pulse on release, and `ButtonLevel[2]` stays 1.
   - With a 12-cycle release gap instead, `ButtonLevel[2]` falls and a second 3'b100 pulse appears 9 edges after the re-press.
5. **Simultaneous:** all bits pressed on the same edge → `ButtonVector`=3'b111 for one cycle. With bit0 delayed by 2 cycles, 3'b110 and 3'b001 appear 2 cycles apart.
6. **Mid-count reset:** bit0 pressed, then `Reset` pulsed at count 5 → no pulse at the original edge 9. The pulse arrives 9 edges after `Reset` deasserts.
